// File: rtl/spike_event_fifo_pkg.sv
// rtl/spike_event_fifo_pkg.sv - network-wide spike event widths, event type and field helpers
package spike_event_fifo_pkg;

   localparam int TEN_DATA_WIDTH  = 2;
   localparam int NEURON_ID_WIDTH = 10;
   localparam int EVT_WIDTH       = TEN_DATA_WIDTH + NEURON_ID_WIDTH;

   // Spike value sits in the MSBs, neuron ID in the LSBs
   typedef logic [EVT_WIDTH-1:0]       evt_t;
   typedef logic [TEN_DATA_WIDTH-1:0]  spike_t;
   typedef logic [NEURON_ID_WIDTH-1:0] neuron_id_t;

   function automatic spike_t evt_spike(input evt_t e);
      return e[EVT_WIDTH-1 -: TEN_DATA_WIDTH];
   endfunction

   function automatic neuron_id_t evt_id(input evt_t e);
      return e[NEURON_ID_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/spike_event_fifo_if.sv
// rtl/spike_event_fifo_if.sv - valid/ready event stream from the FIFO to the weight-fetch consumer
interface spike_event_fifo_if;
   import spike_event_fifo_pkg::*;

   logic evt_valid;
   evt_t evt_data;
   logic evt_ready;

   // FIFO side drives valid/data, consumer side drives ready
   modport master (output evt_valid, output evt_data, input evt_ready);
   modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x WIDTH register array, one write port and one asynchronous read port
module sync_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is intentionally not reset; the pointers define which entries are live
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/spike_event_fifo.sv
// rtl/spike_event_fifo.sv - captures one spike event per network round into a FWFT FIFO, counts overflow drops
module spike_event_fifo
   import spike_event_fifo_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int FILTER_ZERO    = 1,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      net_done,
   input  evt_t                      spike_evt,
   input  logic                      flush,
   spike_event_fifo_if.master        evt,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      full,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             valid;
   logic             zero_spike;
   logic             wr_req;
   logic             pop;
   logic             wr_en;
   logic             drop;
   evt_t             rdata;

   // Zero-valued spikes carry no information for the synapse stage when filtering is on
   assign zero_spike = (FILTER_ZERO != 0) && (evt_spike(spike_evt) == '0);
   assign wr_req     = net_done & ~zero_spike;

   assign valid = (fifo_count != '0);
   assign full  = (fifo_count == CNT_W'(DEPTH));
   assign pop   = valid & evt.evt_ready;

   // A full FIFO still takes a write when the head leaves in the same cycle
   assign wr_en = wr_req & (~full | pop);
   assign drop  = wr_req & full & ~pop;

   sync_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (EVT_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en & ~flush & ~reset),
      .waddr (wr_ptr),
      .wdata (spike_evt),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   assign evt.evt_valid = valid;
   assign evt.evt_data  = rdata;

   // Pointer, occupancy and drop-counter update; reset beats flush, flush beats traffic
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         drop_cnt   <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
         end
      end
   end

endmodule
